// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//
// Fetches 16-bit instruction words from memory one at a time, issues each one
// to the socket array for a single cycle, and then works out the next program
// counter. Two conditions halt the sequencer: an illegal instruction reported
// by the socket array, and a memory fetch that does not complete in time.
// A start pulse in IDLE or HALT (re)starts execution from RESET_ADDRESS.
//
// Parameters
//   RESET_ADDRESS  first word address fetched after reset or restart
//   MAX_WAIT       FETCH cycles with mem_ready low that trigger a timeout (1-255)
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   start               start pulse, honoured in IDLE and HALT only
//   mem_req             instruction-fetch request (high in FETCH)
//   mem_addr            fetch word address (equals pc)
//   mem_ready           fetch data valid this cycle
//   mem_rdata           fetched instruction word
//   instruction         issued word, nop (16'h0100) when not issuing
//   instruction_valid   high exactly in ISSUE cycles
//   illegal_instruction decode fault, sampled in ISSUE
//   branch_taken        redirect request, sampled in ISSUE
//   branch_address      redirect target word address
//   unit_busy           functional unit cannot take the next instruction
//   pc                  current instruction word address
//   halted              sequencer is in HALT
//   fault               0 none, 1 illegal instruction, 2 fetch timeout
//   retired_count       legally issued instructions, saturating
// -----------------------------------------------------------------------------
module instruction_sequencer #(
    parameter logic [14:0] RESET_ADDRESS = 15'h0000,
    parameter int unsigned MAX_WAIT      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        mem_req,
    output logic [14:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instruction,
    output logic        instruction_valid,
    input  logic        illegal_instruction,
    input  logic        branch_taken,
    input  logic [14:0] branch_address,
    input  logic        unit_busy,
    output logic [14:0] pc,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [15:0] retired_count
);

    localparam logic [15:0] NOP        = 16'h0100;
    localparam logic [1:0]  FAULT_NONE = 2'd0;
    localparam logic [1:0]  FAULT_ILL  = 2'd1;
    localparam logic [1:0]  FAULT_TMO  = 2'd2;
    // Last wait-counter value at which mem_ready may still arrive.
    localparam logic [7:0]  WAIT_LAST  = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_STALL,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  fault_q, fault_d;
    logic [15:0] retired_q, retired_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_ADDRESS;
            ir_q      <= NOP;
            wait_q    <= '0;
            fault_q   <= FAULT_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        fault_d   = fault_q;
        retired_d = retired_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end

            S_FETCH: begin
                // Data arriving in the expiry cycle still counts as a hit.
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = FAULT_TMO;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_ISSUE: begin
                if (illegal_instruction) begin
                    fault_d = FAULT_ILL;
                    state_d = S_HALT;
                end else begin
                    if (retired_q != 16'hFFFF) begin
                        retired_d = retired_q + 16'd1;
                    end
                    pc_d = branch_taken ? branch_address : pc_q + 15'd1;
                    // The next pc is committed here even when stalling, so
                    // STALL only has to wait for the unit to free up.
                    if (unit_busy) begin
                        state_d = S_STALL;
                    end else begin
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end
                end
            end

            S_STALL: begin
                if (!unit_busy) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end

            S_HALT: begin
                if (start) begin
                    pc_d      = RESET_ADDRESS;
                    fault_d   = FAULT_NONE;
                    retired_d = '0;
                    wait_d    = '0;
                    state_d   = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs come from registers or state decode, so reset reaches them
    // without waiting for a clock edge.
    assign mem_req           = (state_q == S_FETCH);
    assign mem_addr          = pc_q;
    assign instruction_valid = (state_q == S_ISSUE);
    assign instruction       = (state_q == S_ISSUE) ? ir_q : NOP;
    assign pc                = pc_q;
    assign halted            = (state_q == S_HALT);
    assign fault             = fault_q;
    assign retired_count     = retired_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instruction_valid;
    logic        illegal_instruction;
    logic        branch_taken;
    logic [14:0] branch_address;
    logic        unit_busy;
    logic [14:0] pc;
    logic        halted;
    logic [1:0]  fault;
    logic [15:0] retired_count;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    int          exp_retired = 0;

    instruction_sequencer #(
        .RESET_ADDRESS(15'h0000),
        .MAX_WAIT     (15)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ready          (mem_ready),
        .mem_rdata          (mem_rdata),
        .instruction        (instruction),
        .instruction_valid  (instruction_valid),
        .illegal_instruction(illegal_instruction),
        .branch_taken       (branch_taken),
        .branch_address     (branch_address),
        .unit_busy          (unit_busy),
        .pc                 (pc),
        .halted             (halted),
        .fault              (fault),
        .retired_count      (retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answer the fetch in progress after `waits` idle cycles; counts mem_req
    // cycles and leaves the DUT one cycle after the ready cycle.
    task automatic serve(input logic [15:0] word, input int waits,
                         output int req_cycles, output logic [14:0] addr_seen);
        req_cycles = 0;
        addr_seen  = mem_addr;
        mem_ready  = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = word;
        exp_q.push_back(word);
        if (mem_req === 1'b1) req_cycles++;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    // Fetch + issue one legal instruction with the given control inputs.
    task automatic run_instr(input logic [15:0] word, input int waits,
                             input logic br, input logic [14:0] ba, input logic busy,
                             output logic [15:0] got, output logic [15:0] exp_w);
        int          rc;
        logic [14:0] a;
        serve(word, waits, rc, a);
        got   = (instruction_valid === 1'b1) ? instruction : 16'hxxxx;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hzzzz;
        branch_taken   = br;
        branch_address = ba;
        unit_busy      = busy;
        tick();
        branch_taken   = 1'b0;
        branch_address = 15'h1234;
        if (exp_retired < 65535) exp_retired++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
        illegal_instruction = 1'b0; branch_taken = 1'b0;
        branch_address = 15'h0; unit_busy = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || instruction !== 16'h0100 || instruction_valid !== 1'b0 ||
            halted !== 1'b0 || fault !== 2'd0 || retired_count !== 16'd0 || pc !== 15'h0) begin
            bad++;
            $display("FAIL reset_values: req=%b instr=%h valid=%b halted=%b fault=%0d ret=%0d pc=%h expected 0 0100 0 0 0 0 0000",
                     mem_req, instruction, instruction_valid, halted, fault, retired_count, pc);
        end
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mem_req !== 1'b0) begin
                bad++;
                $display("FAIL no_fetch_before_start: mem_req=%b expected 0", mem_req);
            end
        end
    endtask

    task automatic test_basic_fetch();
        int          rc;
        logic [14:0] a;
        start = 1'b1;
        tick();
        start = 1'b0;
        serve(16'h0101, 2, rc, a);
        total++;
        if (rc != 3 || a !== 15'h0000) begin
            bad++;
            $display("FAIL fetch_req_cycles: cycles=%0d addr=%h expected 3 0000", rc, a);
        end
        total++;
        if (instruction_valid !== 1'b1 || mem_req !== 1'b0 || exp_q.size() == 0 ||
            instruction !== exp_q[0]) begin
            bad++;
            $display("FAIL issue_basic: valid=%b req=%b instr=%h expected 1 0 0101",
                     instruction_valid, mem_req, instruction);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick();
        if (exp_retired < 65535) exp_retired++;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0001 || retired_count !== 16'(exp_retired)) begin
            bad++;
            $display("FAIL next_fetch: req=%b addr=%h ret=%0d expected 1 0001 %0d",
                     mem_req, mem_addr, retired_count, exp_retired);
        end
    endtask

    task automatic test_branch();
        logic [15:0] got, w;
        run_instr(16'hA001, 0, 1'b1, 15'h0010, 1'b0, got, w);
        total++;
        if (got !== w || mem_addr !== 15'h0010) begin
            bad++;
            $display("FAIL branch_to_0010: instr=%h addr=%h expected %h 0010", got, mem_addr, w);
        end
        run_instr(16'hA002, 1, 1'b1, 15'h0200, 1'b0, got, w);
        total++;
        if (got !== w || mem_addr !== 15'h0200 || mem_req !== 1'b1) begin
            bad++;
            $display("FAIL branch_to_0200: instr=%h addr=%h req=%b expected %h 0200 1", got, mem_addr, mem_req, w);
        end
        run_instr(16'hA003, 0, 1'b0, 15'h7777, 1'b0, got, w);
        total++;
        if (got !== w || mem_addr !== 15'h0201) begin
            bad++;
            $display("FAIL not_taken_incr: instr=%h addr=%h expected %h 0201", got, mem_addr, w);
        end
        run_instr(16'hA004, 0, 1'b1, 15'h7FFF, 1'b0, got, w);
        run_instr(16'hA005, 3, 1'b0, 15'h0123, 1'b0, got, w);
        total++;
        if (got !== w || mem_addr !== 15'h0000 || pc !== 15'h0000) begin
            bad++;
            $display("FAIL pc_wrap: instr=%h addr=%h pc=%h expected %h 0000 0000", got, mem_addr, pc, w);
        end
        total++;
        if (retired_count !== 16'(exp_retired)) begin
            bad++;
            $display("FAIL retired_after_branches: ret=%0d expected %0d", retired_count, exp_retired);
        end
    endtask

    task automatic test_stall();
        logic [15:0] got, w;
        int          stalls;
        bit          quiet;
        run_instr(16'hB001, 0, 1'b0, 15'h0, 1'b1, got, w);
        total++;
        if (got !== w) begin
            bad++;
            $display("FAIL stall_issue: instr=%h expected %h", got, w);
        end
        stalls = 0;
        quiet  = 1'b1;
        // start and branch_taken are both noise while stalled.
        start = 1'b1;
        branch_taken = 1'b1;
        branch_address = 15'h4444;
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) begin
            stalls++;
            if (instruction_valid !== 1'b0 || instruction !== 16'h0100) quiet = 1'b0;
            if (stalls == 4) unit_busy = 1'b0;
            tick();
        end
        start = 1'b0;
        branch_taken = 1'b0;
        total++;
        if (stalls != 4 || !quiet) begin
            bad++;
            $display("FAIL stall_cycles: stalls=%0d quiet=%0b expected 4 1", stalls, quiet);
        end
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0001 || retired_count !== 16'(exp_retired)) begin
            bad++;
            $display("FAIL stall_refetch: req=%b addr=%h ret=%0d expected 1 0001 %0d",
                     mem_req, mem_addr, retired_count, exp_retired);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] got, w;
        int          rc;
        logic [14:0] a;
        run_instr(16'hC001, 0, 1'b1, 15'h0005, 1'b0, got, w);
        serve(16'hC0FF, 1, rc, a);
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hzzzz;
        total++;
        if (instruction !== w || a !== 15'h0005) begin
            bad++;
            $display("FAIL illegal_issue: instr=%h addr=%h expected %h 0005", instruction, a, w);
        end
        illegal_instruction = 1'b1;
        tick();
        illegal_instruction = 1'b0;
        total++;
        if (halted !== 1'b1 || fault !== 2'd1 || pc !== 15'h0005 || mem_req !== 1'b0 ||
            retired_count !== 16'(exp_retired)) begin
            bad++;
            $display("FAIL illegal_halt: halted=%b fault=%0d pc=%h req=%b ret=%0d expected 1 1 0005 0 %0d",
                     halted, fault, pc, mem_req, retired_count, exp_retired);
        end
        tick();
        total++;
        if (halted !== 1'b1 || fault !== 2'd1) begin
            bad++;
            $display("FAIL halt_holds: halted=%b fault=%0d expected 1 1", halted, fault);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_retired = 0;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0000 || fault !== 2'd0 ||
            retired_count !== 16'd0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL restart: req=%b addr=%h fault=%0d ret=%0d halted=%b expected 1 0000 0 0 0",
                     mem_req, mem_addr, fault, retired_count, halted);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] got, w;
        int          rc;
        rc = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (mem_req === 1'b1) rc++;
            tick();
        end
        total++;
        if (rc != 15 || halted !== 1'b1 || fault !== 2'd2 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout: req_cycles=%0d halted=%b fault=%0d req=%b expected 15 1 2 0",
                     rc, halted, fault, mem_req);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_retired = 0;
        run_instr(16'hD00D, 14, 1'b0, 15'h0, 1'b0, got, w);
        total++;
        if (got !== w || fault !== 2'd0 || halted !== 1'b0 || mem_addr !== 15'h0001) begin
            bad++;
            $display("FAIL ready_on_last_wait: instr=%h fault=%0d halted=%b addr=%h expected %h 0 0 0001",
                     got, fault, halted, mem_addr, w);
        end
    endtask

    task automatic test_reset_in_stall();
        logic [15:0] got, w;
        run_instr(16'hE001, 0, 1'b0, 15'h0, 1'b0, got, w);
        run_instr(16'hE002, 2, 1'b0, 15'h0, 1'b1, got, w);
        total++;
        if (retired_count !== 16'd3 || exp_retired != 3 || mem_req !== 1'b0 || instruction_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_before_reset: ret=%0d req=%b valid=%b expected 3 0 0",
                     retired_count, mem_req, instruction_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || instruction !== 16'h0100 || instruction_valid !== 1'b0 ||
            halted !== 1'b0 || fault !== 2'd0 || retired_count !== 16'd0 || pc !== 15'h0) begin
            bad++;
            $display("FAIL async_reset_stall: req=%b instr=%h valid=%b halted=%b fault=%0d ret=%0d pc=%h expected 0 0100 0 0 0 0 0000",
                     mem_req, instruction, instruction_valid, halted, fault, retired_count, pc);
        end
        unit_busy = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        total++;
        if (mem_req !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: req=%b halted=%b expected 0 0", mem_req, halted);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch();
        test_stall();
        test_illegal();
        test_timeout();
        test_reset_in_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter RESET_ADDRESS, default 15'h0000, first word address fetched after reset or restart.
REQ-002 Parameter MAX_WAIT, default 15, memory-wait cycles before timeout fault (range 1-255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 start  input  1  pulse; starts execution from IDLE or HALT.
REQ-006 mem_req  output  1  instruction-fetch request.
REQ-007 mem_addr  output  15  word address of fetch (equals pc).
REQ-008 mem_ready  input  1  fetch data valid this cycle.
REQ-009 mem_rdata  input  16  fetched instruction word.
REQ-010 instruction  output  16  word driven to socket array; 16'h0100 (nop: alpha 0, omega 1) when not issuing.
REQ-011 instruction_valid  output  1  high exactly in ISSUE cycles.
REQ-012 illegal_instruction  input  1  decode fault from socket array, sampled in ISSUE only.
REQ-013 branch_taken  input  1  control-flow unit redirect, sampled in ISSUE only.
REQ-014 branch_address  input  15  redirect target word address.
REQ-015 unit_busy  input  1  a functional unit cannot accept the next instruction.
REQ-016 pc  output  15  current instruction word address.
REQ-017 halted  output  1  sequencer in HALT.
REQ-018 fault  output  2  0 none, 1 illegal instruction, 2 fetch timeout; valid while halted.
REQ-019 retired_count  output  16  count of legally issued instructions, saturating.

Function
REQ-020 States SHALL be IDLE, FETCH, ISSUE, STALL, HALT.
REQ-021 IDLE: mem_req 0, instruction_valid 0; start -> FETCH.
REQ-022 FETCH: mem_req 1, mem_addr = pc; mem_ready -> latch mem_rdata, go ISSUE next cycle (fetch latency 1 cycle after mem_ready).
REQ-023 FETCH: wait counter increments each cycle mem_ready low; reaching MAX_WAIT with mem_ready low -> HALT, fault 2; mem_ready in expiry cycle wins, no fault.
REQ-024 Wait counter SHALL clear on every FETCH entry.
REQ-025 ISSUE: instruction = latched word, instruction_valid 1 for one cycle, mem_req 0.
REQ-026 ISSUE with illegal_instruction 1 -> HALT, fault 1, pc unchanged, retired_count unchanged.
REQ-027 ISSUE legal: retired_count +1 (holds at 16'hFFFF); next pc = branch_address if branch_taken else pc+1, 15'h7FFF+1 wraps to 15'h0000.
REQ-028 ISSUE legal, unit_busy 0 -> FETCH with next pc; unit_busy 1 -> STALL, next pc already committed.
REQ-029 STALL: instruction nop, instruction_valid 0, mem_req 0; unit_busy 0 -> FETCH; branch_taken ignored.
REQ-030 HALT: halted 1, fault held; start -> pc = RESET_ADDRESS, fault 0, retired_count 0, FETCH.
REQ-031 start in FETCH, ISSUE or STALL SHALL be ignored.
REQ-032 Outputs SHALL be registered or decoded from state only; no input-to-output combinational path except none.

Reset
REQ-033 rst_n low at any time, including mid-fetch or mid-stall, SHALL immediately force IDLE, pc = RESET_ADDRESS, mem_req 0, instruction 16'h0100, instruction_valid 0, halted 0, fault 0, retired_count 0, wait counter 0.
REQ-034 After rst_n release, no fetch until start.

Verification
REQ-035 Reset, start, memory returns 16'h0101 after 2 wait cycles at 0x0000 -> mem_req 3 cycles, ISSUE next cycle with instruction 16'h0101, then fetch at 0x0001, retired_count 1.
REQ-036 ISSUE at pc 0x0010 with branch_taken 1, branch_address 0x0200 -> next mem_addr 0x0200; same with pc 0x7FFF, branch_taken 0 -> next mem_addr 0x0000.
REQ-037 ISSUE with unit_busy 1 for 4 cycles -> 4 STALL cycles, mem_req 0, then fetch of pc+1; busy-to-fetch latency 1 cycle.
REQ-038 ISSUE with illegal_instruction 1 at pc 0x0005 -> halted 1, fault 1, pc 0x0005; start -> fetch at 0x0000, fault 0, retired_count 0.
REQ-039 mem_ready held low MAX_WAIT (15) cycles -> halted, fault 2; repeat with mem_ready on 15th cycle -> ISSUE, no fault.
REQ-040 rst_n asserted during STALL with retired_count 3 -> all outputs at reset values asynchronously, before next clk edge.
